// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter for the register file's single write port.
// ALU results always win the port and are never stalled. Load results are
// accepted through a valid/ready handshake and buffered in a small in-order
// queue that drains one entry per ALU-idle cycle. An ALU write squashes every
// queued load to the same register (write-after-write), so the ALU value stays
// the youngest. busy[r] flags registers that still await a live queued load.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   alu_valid/addr/data/flags    ALU result (highest priority)
//   ld_valid/ready/addr/data     load result handshake
//   rf_wr_en/addr, rf_dat_in     registered register-file write port
//   rf_zero/ngtv/scry            registered register-file flag inputs
//   busy                         registered per-register pending-load mask
//   sq_cnt                       registered squashed-load counter
//
// Build option: define RF_WB_SQUASH_CNT_EN to include the saturating squash
// counter; without it sq_cnt is tied to zero.
module rf_wb_arbiter #(
    parameter int unsigned PW       = 3,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [PW-1:0]       alu_addr,
    input  logic [7:0]          alu_data,
    input  logic                alu_zero,
    input  logic                alu_ngtv,
    input  logic                alu_scry,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [PW-1:0]       ld_addr,
    input  logic [7:0]          ld_data,
    output logic                rf_wr_en,
    output logic [PW-1:0]       rf_wr_addr,
    output logic [7:0]          rf_dat_in,
    output logic                rf_zero,
    output logic                rf_ngtv,
    output logic                rf_scry,
    output logic [(2**PW)-1:0]  busy,
    output logic [15:0]         sq_cnt
);

    localparam int unsigned NREG = 2**PW;
    localparam int unsigned CW   = $clog2(LQ_DEPTH + 1);

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [7:0]    data;
        logic          live;
    } lq_entry_t;

    // Queue is kept as a shift register: entry 0 is always the head.
    lq_entry_t     q   [LQ_DEPTH];
    lq_entry_t     q_n [LQ_DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          push;
    logic [NREG-1:0] busy_n;
    logic [2:0]    shadow;

    logic          wr_en_n;
    logic [PW-1:0] wr_addr_n;
    logic [7:0]    wr_data_n;
    logic [2:0]    wr_flags_n;

    // Fullness is judged on the current count, so a same-cycle pop never frees a slot early.
    assign ld_ready = !reset && (cnt < CW'(LQ_DEPTH));
    assign push     = ld_valid && ld_ready;

    // Queue next state: squash on ALU write, pop on idle ALU, then append.
    always_comb begin
        q_n   = q;
        cnt_n = cnt;
        if (alu_valid) begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                if ((CW'(i) < cnt) && (q[i].addr == alu_addr)) begin
                    q_n[i].live = 1'b0;
                end
            end
        end else if (cnt != '0) begin
            for (int unsigned i = 0; i + 1 < LQ_DEPTH; i++) begin
                q_n[i] = q[i+1];
            end
            cnt_n = cnt - CW'(1);
        end
        // A load that meets an empty queue and an idle ALU bypasses the queue.
        if (push && (alu_valid || (cnt != '0))) begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                if (CW'(i) == cnt_n) begin
                    q_n[i].addr = ld_addr;
                    q_n[i].data = ld_data;
                    q_n[i].live = !(alu_valid && (ld_addr == alu_addr));
                end
            end
            cnt_n = cnt_n + CW'(1);
        end
    end

    // Pending-load mask of the post-edge queue.
    always_comb begin
        busy_n = '0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if ((CW'(i) < cnt_n) && q_n[i].live) begin
                busy_n[q_n[i].addr] = 1'b1;
            end
        end
    end

    // Write-port selection: ALU, else queue head, else direct load.
    always_comb begin
        wr_en_n    = 1'b0;
        wr_addr_n  = ld_addr;
        wr_data_n  = ld_data;
        wr_flags_n = shadow;
        if (alu_valid) begin
            wr_en_n    = 1'b1;
            wr_addr_n  = alu_addr;
            wr_data_n  = alu_data;
            wr_flags_n = {alu_zero, alu_ngtv, alu_scry};
        end else if (cnt != '0) begin
            wr_en_n    = q[0].live;
            wr_addr_n  = q[0].addr;
            wr_data_n  = q[0].data;
        end else if (push) begin
            wr_en_n    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                q[i] <= '0;
            end
            cnt        <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_dat_in  <= '0;
            rf_zero    <= 1'b0;
            rf_ngtv    <= 1'b0;
            rf_scry    <= 1'b0;
            shadow     <= '0;
            busy       <= '0;
        end else begin
            q        <= q_n;
            cnt      <= cnt_n;
            rf_wr_en <= wr_en_n;
            busy     <= busy_n;
            if (wr_en_n) begin
                rf_wr_addr <= wr_addr_n;
                rf_dat_in  <= wr_data_n;
                {rf_zero, rf_ngtv, rf_scry} <= wr_flags_n;
            end
            if (alu_valid) begin
                shadow <= {alu_zero, alu_ngtv, alu_scry};
            end
        end
    end

`ifdef RF_WB_SQUASH_CNT_EN
    localparam int unsigned SW = $clog2(LQ_DEPTH + 2);

    logic [SW-1:0] sq_inc;
    logic [16:0]   sq_sum;
    logic [15:0]   sq_q;

    // Live entries killed this cycle, including a same-address load accepted now.
    always_comb begin
        sq_inc = '0;
        if (alu_valid) begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
                if ((CW'(i) < cnt) && q[i].live && (q[i].addr == alu_addr)) begin
                    sq_inc = sq_inc + SW'(1);
                end
            end
            if (push && (ld_addr == alu_addr)) begin
                sq_inc = sq_inc + SW'(1);
            end
        end
    end

    assign sq_sum = {1'b0, sq_q} + 17'(sq_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_sum[16] ? 16'hFFFF : sq_sum[15:0];
        end
    end

    assign sq_cnt = sq_q;
`else
    assign sq_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_rf_wb_arbiter;

    localparam int unsigned PW = 3;
    localparam int unsigned D  = 2;
`ifdef RF_WB_SQUASH_CNT_EN
    localparam int SQ_ON = 1;
`else
    localparam int SQ_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [2:0] alu_addr;
    logic [7:0] alu_data;
    logic       alu_zero, alu_ngtv, alu_scry;
    logic       ld_valid;
    logic       ld_ready;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic       rf_wr_en;
    logic [2:0] rf_wr_addr;
    logic [7:0] rf_dat_in;
    logic       rf_zero, rf_ngtv, rf_scry;
    logic [7:0] busy;
    logic [15:0] sq_cnt;

    rf_wb_arbiter #(.PW(PW), .LQ_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .alu_zero(alu_zero), .alu_ngtv(alu_ngtv), .alu_scry(alu_scry),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
        .rf_zero(rf_zero), .rf_ngtv(rf_ngtv), .rf_scry(rf_scry),
        .busy(busy), .sq_cnt(sq_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        bit         live;
    } ment_t;
    ment_t       mq[$];
    bit          e_wr_en;
    logic [2:0]  e_addr;
    logic [7:0]  e_data;
    logic [2:0]  e_flags;
    logic [2:0]  m_shadow;
    logic [7:0]  e_busy;
    int unsigned m_sq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                         input logic [2:0] af, input logic lv, input logic [2:0] la,
                         input logic [7:0] ldd, input logic rst);
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        {alu_zero, alu_ngtv, alu_scry} = af;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ldd;
        reset     = rst;
    endtask

    // One clock edge of the arbiter, described in terms of a FIFO of loads.
    task automatic model_edge(input bit push);
        ment_t e;
        if (reset) begin
            mq.delete();
            e_wr_en = 1'b0; e_addr = '0; e_data = '0; e_flags = '0;
            m_shadow = '0; e_busy = '0; m_sq = 0;
            return;
        end
        e_wr_en = 1'b0;
        if (alu_valid) begin
            e_wr_en  = 1'b1;
            e_addr   = alu_addr;
            e_data   = alu_data;
            e_flags  = {alu_zero, alu_ngtv, alu_scry};
            m_shadow = e_flags;
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].addr == alu_addr) begin
                    mq[i].live = 1'b0;
                    m_sq++;
                end
            end
            if (push) begin
                e.addr = ld_addr; e.data = ld_data; e.live = (ld_addr != alu_addr);
                if (!e.live) m_sq++;
                mq.push_back(e);
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live) begin
                e_wr_en = 1'b1; e_addr = e.addr; e_data = e.data; e_flags = m_shadow;
            end
            if (push) begin
                e.addr = ld_addr; e.data = ld_data; e.live = 1'b1;
                mq.push_back(e);
            end
        end else if (push) begin
            e_wr_en = 1'b1; e_addr = ld_addr; e_data = ld_data; e_flags = m_shadow;
        end
        if (m_sq > 65535) m_sq = 65535;
        e_busy = '0;
        foreach (mq[i]) begin
            if (mq[i].live) e_busy[mq[i].addr] = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        chk("rf_wr_en", 32'(rf_wr_en), 32'(e_wr_en));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("sq_cnt", 32'(sq_cnt), (SQ_ON != 0) ? 32'(m_sq) : 32'd0);
        if (e_wr_en) begin
            chk("rf_wr_addr", 32'(rf_wr_addr), 32'(e_addr));
            chk("rf_dat_in", 32'(rf_dat_in), 32'(e_data));
            chk("rf_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'(e_flags));
        end
    endtask

    // Inputs are already applied; check ready, advance one edge, compare.
    task automatic step();
        bit push;
        bit rdy;
        #1;
        rdy  = !reset && (mq.size() < int'(D));
        chk("ld_ready", 32'(ld_ready), 32'(rdy));
        push = ld_valid && rdy;
        @(posedge clk);
        model_edge(push);
        #1;
        compare_outputs();
    endtask

    initial begin
        logic [2:0] la;
        logic [7:0] ldd;

        // Reset
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 1'b1);
        step();
        step();
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
        chk("rst_addr", 32'(rf_wr_addr), 32'd0);
        chk("rst_data", 32'(rf_dat_in), 32'd0);
        chk("rst_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sq", 32'(sq_cnt), 32'd0);

        // Direct load on idle port
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b1, 3'd3, 8'h5A, 1'b0);
        step();
        chk("t1_wr_en", 32'(rf_wr_en), 32'd1);
        chk("t1_addr", 32'(rf_wr_addr), 32'd3);
        chk("t1_data", 32'(rf_dat_in), 32'h5A);
        chk("t1_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_ready", 32'(ld_ready), 32'd1);

        // ALU and load together: load is queued, then written with shadow flags
        drive(1'b1, 3'd1, 8'h00, 3'b100, 1'b1, 3'd2, 8'h11, 1'b0);
        step();
        chk("t2_alu_wr", 32'(rf_wr_en), 32'd1);
        chk("t2_alu_addr", 32'(rf_wr_addr), 32'd1);
        chk("t2_alu_data", 32'(rf_dat_in), 32'h00);
        chk("t2_alu_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'b100);
        chk("t2_busy_hi", 32'(busy), 32'h04);
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("t2_ld_wr", 32'(rf_wr_en), 32'd1);
        chk("t2_ld_addr", 32'(rf_wr_addr), 32'd2);
        chk("t2_ld_data", 32'(rf_dat_in), 32'h11);
        chk("t2_ld_flags", 32'({rf_zero, rf_ngtv, rf_scry}), 32'b100);
        chk("t2_busy_lo", 32'(busy), 32'd0);

        // ALU busy for 4 cycles with 3 loads offered: queue fills, then drains in order
        for (int k = 0; k < 4; k++) begin
            la  = (k == 0) ? 3'd5 : (k == 1) ? 3'd6 : 3'd7;
            ldd = (k == 0) ? 8'hA1 : (k == 1) ? 8'hA2 : 8'hA3;
            drive(1'b1, 3'd0, 8'(8'hC0 + k), 3'b000, 1'b1, la, ldd, 1'b0);
            step();
            if (k >= 1) chk("t3_ready_low", 32'(ld_ready), 32'd0);
        end
        chk("t3_busy_full", 32'(busy), 32'h60);
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b1, 3'd7, 8'hA3, 1'b0);
        step();
        chk("t3_pop1_addr", 32'(rf_wr_addr), 32'd5);
        chk("t3_pop1_data", 32'(rf_dat_in), 32'hA1);
        step();
        chk("t3_pop2_addr", 32'(rf_wr_addr), 32'd6);
        chk("t3_pop2_data", 32'(rf_dat_in), 32'hA2);
        chk("t3_busy_r7", 32'(busy), 32'h80);
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("t3_pop3_addr", 32'(rf_wr_addr), 32'd7);
        chk("t3_pop3_data", 32'(rf_dat_in), 32'hA3);
        chk("t3_busy_empty", 32'(busy), 32'd0);

        // Queued load to r5 squashed by a later ALU write to r5
        drive(1'b1, 3'd0, 8'h01, 3'b000, 1'b1, 3'd5, 8'h33, 1'b0);
        step();
        chk("t4_busy_r5", 32'(busy), 32'h20);
        drive(1'b1, 3'd5, 8'h77, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("t4_alu_addr", 32'(rf_wr_addr), 32'd5);
        chk("t4_alu_data", 32'(rf_dat_in), 32'h77);
        chk("t4_busy_clr", 32'(busy), 32'd0);
        chk("t4_sq", 32'(sq_cnt), 32'(SQ_ON));
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("t4_dead_pop", 32'(rf_wr_en), 32'd0);
        chk("t4_r5_kept", 32'(rf_dat_in), 32'h77);

        // Same-cycle ALU and load to r4
        drive(1'b1, 3'd4, 8'h44, 3'b000, 1'b1, 3'd4, 8'h99, 1'b0);
        step();
        chk("t5_addr", 32'(rf_wr_addr), 32'd4);
        chk("t5_data", 32'(rf_dat_in), 32'h44);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sq", 32'(sq_cnt), 32'(2 * SQ_ON));
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("t5_dead_pop", 32'(rf_wr_en), 32'd0);

        // Reset with two queued loads
        drive(1'b1, 3'd0, 8'h02, 3'b000, 1'b1, 3'd1, 8'h10, 1'b0);
        step();
        drive(1'b1, 3'd0, 8'h03, 3'b000, 1'b1, 3'd2, 8'h20, 1'b0);
        step();
        chk("t6_busy_q2", 32'(busy), 32'h06);
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b1, 3'd3, 8'h30, 1'b1);
        step();
        chk("t6_ready_rst", 32'(ld_ready), 32'd0);
        chk("t6_wr_rst", 32'(rf_wr_en), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_sq_rst", 32'(sq_cnt), 32'd0);
        drive(1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("t6_no_write", 32'(rf_wr_en), 32'd0);
        chk("t6_ready_after", 32'(ld_ready), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 99) < 45, 3'($urandom_range(0, 7)), 8'($urandom),
                  3'($urandom), $urandom_range(0, 99) < 70, 3'($urandom_range(0, 7)),
                  8'($urandom), $urandom_range(0, 199) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scheduler for the 8-bit register file's single write port. It merges ALU results (highest priority, never stalled) with load-unit results, which are buffered in a small in-order queue. It drives the register file's write port and flag inputs, and tracks which registers still await a load write so decode can stall on them. It sits between the execute/memory stages and the register file, and is the only module allowed to drive the register file write port.

## Interface
Parameters:
- PW, 3, register address width (2**PW registers)
- LQ_DEPTH, 2, load queue depth, ≥1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid this cycle
- alu_addr  in  PW  ALU destination register
- alu_data  in  8  ALU result
- alu_zero, alu_ngtv, alu_scry  in  1 each  ALU flag results
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- ld_addr  in  PW  load destination register
- ld_data  in  8  load data
- rf_wr_en  out  1  register file write enable
- rf_wr_addr  out  PW  register file write address
- rf_dat_in  out  8  register file write data
- rf_zero, rf_ngtv, rf_scry  out  1 each  register file flag inputs
- busy  out  2**PW  bit r set = a live load write to register r is pending
- sq_cnt  out  16  squashed-load counter (see Configuration)

## Operation
- Load queue: FIFO of LQ_DEPTH entries {addr, data, live}. A push occurs on ld_valid && ld_ready. ld_ready = !reset && (count < LQ_DEPTH). A pop and a push in the same cycle are not allowed to bypass the full check.
- Arbitration per cycle:
  - If alu_valid, the ALU result is the write.
  - Else, if the queue is non-empty, the head is popped. It is written only if its live bit is 1. A dead pop produces rf_wr_en=0.
  - Else, if a load handshake occurs this cycle, that load is written directly without enqueueing.
  - Else, no write.
- Load handshake while the ALU writes: the load is enqueued.
- WAW squash: an ALU write to address A clears live on every queued entry with addr==A. A load accepted in the same cycle with ld_addr==A is enqueued with live=0. The ALU result is always the youngest value.
- Flags: ALU writes forward alu_* flags and update a 3-bit flag shadow. Load writes drive rf_* flags from the shadow, so the register file's flags are unchanged by loads.
- busy: OR over queued live entries of the one-hot of addr. It reflects queue state after the current clock edge and is registered.

## Timing
- All rf_* outputs, busy and sq_cnt are registered.
- A write selected in cycle N appears on rf_* in cycle N+1. The register file captures it at the end of cycle N+1.
- Minimum load latency with an empty queue and no ALU write: handshake in N, rf_wr_en in N+1.
- Queued load latency: pops at 1 entry/cycle in idle ALU cycles, strict FIFO order. A continuous alu_valid starves the queue indefinitely, by design.
- Reset, synchronous:
  - queue empty; count 0
  - rf_wr_en 0; rf_wr_addr 0; rf_dat_in 0; rf flags 0
  - flag shadow 0; busy 0; sq_cnt 0
  - ld_ready 0 during reset, 1 the cycle after
- Reset mid-operation discards all queued loads with no write.

## Configuration
- RF_WB_SQUASH_CNT_EN defined: sq_cnt increments by the number of live entries squashed each cycle, including a same-cycle accepted load. It saturates at 16'hFFFF.
- RF_WB_SQUASH_CNT_EN undefined: sq_cnt is tied to 0 and no counter logic exists. Squash behaviour itself is unchanged.

## Test plan
- Idle, load r3=0x5A → next cycle rf_wr_en=1, addr 3, data 0x5A, flags = shadow (0 after reset); busy stays 0.
- ALU r1=0x00 with zero=1, and load r2=0x11 in the same cycle → cycle+1: ALU write r1 with zero=1; cycle+2: r2=0x11 with zero=1 (shadow); busy[2] high for exactly one cycle.
- ALU valid for 4 cycles while offering 3 loads with LQ_DEPTH=2 → ld_ready drops after 2 accepts; the queue drains in order in the first idle cycles.
- Queue holds a load to r5; ALU writes r5=0x77 → the r5 load pops with no write; r5 ends at 0x77; busy[5] clears; sq_cnt=1 with the macro, 0 without.
- Same-cycle ALU r4 and load r4 → only the ALU write occurs; sq_cnt increments.
- Reset asserted with 2 queued loads → no further rf_wr_en; busy=0; ld_ready=0 during reset, then 1.
